br_flow_dispatch_rr: RTL
========================

# br_flow_dispatch_rr

Round-robin 1-to-N flow dispatcher: the distribution-side counterpart to a round-robin arbiter. A single ready/valid push stream is steered to one of NumFlows ready/valid pop interfaces per transfer, in round-robin order, skipping outputs that cannot accept. Each output has a one-entry registered stage, so pop_valid and pop_data come straight from flops. Used to spread work items across parallel identical engines.

## Interface
- NumFlows, default 2, number of pop interfaces; must be >= 2.
- Width, default 1, data width in bits; must be >= 1.

Ports:
- clk  input  1  clock; all state sampled on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- push_valid  input  1  push item present.
- push_ready  output  1  dispatcher accepts the push item this cycle.
- push_data  input  Width  push payload.
- pop_valid  output  NumFlows  per-output item present; registered.
- pop_ready  input  NumFlows  per-output consumer accepts.
- pop_data  output  NumFlows x Width  per-output payload; registered.

## Operation
- State:
  - last_dispatch, a NumFlows-bit onehot; resets to bit NumFlows-1, so output 0 has highest priority.
  - Per output, a valid flop and a Width-bit data flop.
- eligible[i] = !pop_valid[i] || pop_ready[i]. The slot is empty or is draining this cycle.
- Priority order: the output after last_dispatch (modulo NumFlows) is highest. The order wraps around to last_dispatch itself, which is lowest.
- select is a onehot of the highest-priority eligible output; it is all zero if none is eligible.
- push_ready = |eligible. It is forced to 0 while rst is asserted.
- Push accepted (push_valid && push_ready):
  - Load push_data into the selected slot and set its valid.
  - last_dispatch <= select.
- No accepted push: last_dispatch holds. Ineligible outputs never receive data.
- Pop on output i (pop_valid[i] && pop_ready[i]) with no new item for i: valid[i] clears.
- Pop and refill of the same slot in one cycle: valid[i] stays 1 and data is replaced.
- Data flops load only on accept to the selected slot.
- Pop-side stability: once pop_valid[i] is 1, pop_valid[i] and pop_data[i] hold until pop_ready[i].
- Push-side rules, required of the upstream and asserted in the RTL:
  - push_valid && !push_ready holds push_valid and push_data stable next cycle.
  - No X on push_valid.

## Timing
- Latency: an accepted push appears on pop_valid/pop_data at the next clock edge, i.e. 1 cycle.
- Throughput is 1 item/cycle while any output is eligible.
- push_ready has a combinational path from pop_ready, and from state. There is no path from push_valid to push_ready.
- Reset values:
  - pop_valid = 0.
  - pop_data = 0.
  - last_dispatch = onehot(NumFlows-1).
  - push_ready = 0 during reset, and = 1 on the first cycle after reset (all slots empty).
- Reset asserted mid-operation: all slot contents are dropped immediately (asynchronous), and the pointer returns to its reset value. Items in flight are lost by design.
- Wrap-around: after dispatching to NumFlows-1, output 0 is highest priority.
- All outputs full and none popping: push_ready = 0 and the pointer holds.

## Structure
- No shared package is needed; there are no typedefs beyond parameterised vectors.
- One sub-module, br_flow_dispatch_rr_select (combinational):
  - Inputs: last_dispatch and eligible.
  - Output: the onehot select.
  - Implementation: masked and unmasked priority encoders. If the masked eligible vector (bits above last_dispatch) is nonzero, use its lowest set bit; otherwise use the lowest set bit of the unmasked vector.
- The top level holds the pointer register, the per-slot flops, the handshake logic, and the assertions:
  - select is onehot0.
  - push accepted implies |select.
  - The pop stability rule above.

## Test plan
All scenarios use NumFlows=3 and Width=8.
- Reset release, all pop_ready=1, push_valid=1 each cycle with data 0x10,0x11,0x12,0x13 -> items appear on outputs 0,1,2,0 at cycles +1..+4; push_ready is constantly 1.
- Output 1 held full (pop_ready[1]=0) after one item, then push 0xA0,0xA1 -> they go to outputs 2 and 0 (output 1 skipped); pop_data[1] unchanged throughout.
- All outputs full, all pop_ready=0, push_valid=1 with data 0x55 -> push_ready=0 and no pointer change; raise pop_ready[2] -> push_ready=1 the same cycle, and 0x55 lands in output 2 while its old item pops.
- Back-to-back pop and refill on output 0 (only output 0 eligible for 4 cycles) -> pop_valid[0] stays 1 and each cycle shows the next push item.
- Assert rst asynchronously mid-stream with 2 slots full -> pop_valid goes to 0 without a clock edge; after release, the first push goes to output 0.
- Random push/pop traffic for 10k cycles vs. a scoreboard -> no loss or duplication, per-output ordering preserved, dispatch order matches the round-robin model, and no assertion fires.

Source files
------------

// File: rtl/br_flow_dispatch_rr_select.sv
// Round-robin select for the flow dispatcher.
// Picks the lowest eligible output strictly above the last dispatched one;
// if there is none, wraps around and picks the lowest eligible output overall.
module br_flow_dispatch_rr_select #(
    parameter int NumFlows = 2
) (
    input  logic [NumFlows-1:0] last_dispatch,
    input  logic [NumFlows-1:0] eligible,
    output logic [NumFlows-1:0] select
);

    localparam logic [NumFlows-1:0] One = NumFlows'(1);

    logic [NumFlows-1:0] above_mask;
    logic [NumFlows-1:0] masked;
    logic [NumFlows-1:0] masked_pick;
    logic [NumFlows-1:0] unmasked_pick;

    // Masked and unmasked lowest-set-bit encoders, masked result wins when nonzero
    always_comb begin
        // Bits strictly above the onehot pointer: clear the pointer bit and everything below it
        above_mask    = ~(last_dispatch | (last_dispatch - One));
        masked        = eligible & above_mask;
        // x & -x isolates the lowest set bit
        masked_pick   = masked & (~masked + One);
        unmasked_pick = eligible & (~eligible + One);
        select        = (|masked) ? masked_pick : unmasked_pick;
    end

endmodule

// File: rtl/br_flow_dispatch_rr.sv
// Round-robin 1-to-N flow dispatcher.
// One push stream is steered to one of NumFlows single-entry registered
// output slots per transfer, rotating priority and skipping full slots.
module br_flow_dispatch_rr #(
    parameter int NumFlows = 2,
    parameter int Width    = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push_valid,
    output logic                               push_ready,
    input  logic [Width-1:0]                   push_data,
    output logic [NumFlows-1:0]                pop_valid,
    input  logic [NumFlows-1:0]                pop_ready,
    output logic [NumFlows-1:0][Width-1:0]     pop_data
);

    // Output NumFlows-1 was "last", so output 0 starts with top priority
    localparam logic [NumFlows-1:0] PtrReset = NumFlows'(1) << (NumFlows - 1);

    logic [NumFlows-1:0]              last_dispatch_reg;
    logic [NumFlows-1:0]              pop_valid_reg;
    logic [NumFlows-1:0][Width-1:0]   pop_data_reg;
    logic [NumFlows-1:0]              eligible;
    logic [NumFlows-1:0]              select;
    logic                             push_accept;

    // A slot can take a new item if it is empty or drains this cycle
    assign eligible    = ~pop_valid_reg | pop_ready;
    // No dependence on push_valid; held low while reset is active
    assign push_ready  = (|eligible) && !rst;
    assign push_accept = push_valid && push_ready;

    assign pop_valid = pop_valid_reg;
    assign pop_data  = pop_data_reg;

    br_flow_dispatch_rr_select #(
        .NumFlows (NumFlows)
    ) u_select (
        .last_dispatch (last_dispatch_reg),
        .eligible      (eligible),
        .select        (select)
    );

    // Round-robin pointer: advances to the chosen slot only on an accepted push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dispatch_reg <= PtrReset;
        end else if (push_accept) begin
            last_dispatch_reg <= select;
        end
    end

    // Per-slot valid/data: refill has precedence over drain so pop+refill keeps valid high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_valid_reg <= '0;
            pop_data_reg  <= '0;
        end else begin
            for (int i = 0; i < NumFlows; i++) begin
                if (push_accept && select[i]) begin
                    pop_valid_reg[i] <= 1'b1;
                    pop_data_reg[i]  <= push_data;
                end else if (pop_ready[i]) begin
                    pop_valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    // Select must never name more than one output
    a_select_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(select));

    // An accepted push always has a destination
    a_accept_has_select: assert property (@(posedge clk) disable iff (rst)
        push_accept |-> (|select));

    // Upstream must hold a stalled push
    a_push_stable: assert property (@(posedge clk) disable iff (rst)
        (push_valid && !push_ready) |=> (push_valid && $stable(push_data)));

    // Upstream must never drive an unknown push_valid
    a_push_valid_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown(push_valid));

    // Each output holds its item until the consumer takes it
    for (genvar gi = 0; gi < NumFlows; gi++) begin : g_pop_stable
        a_pop_stable: assert property (@(posedge clk) disable iff (rst)
            (pop_valid[gi] && !pop_ready[gi]) |=> (pop_valid[gi] && $stable(pop_data[gi])));
    end

endmodule
